wreq_sched_subo: RTL and testbench

Subordinate-side write-request scheduler. It accepts AXI write-address (AW) transactions one at a time and starts the write-data channel subordinate for each burst. When that channel reports the burst complete, it pushes the assembled 128-bit line plus address into a small write queue, then returns a B response. It owns the queue-pressure signal `sqfull_1` that throttles the data channel.

---
 rtl/wreq_sched_subo.sv | 161 ++++++++++++++++
 tb/tb_wreq_sched_subo.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/wreq_sched_subo.sv
// Subordinate write-request scheduler: AW accept, data-channel start, line queue, B response.
// Optional macro WREQ_LENCHK_EN: reject awlen > 3 with SLVERR and skip the queue push.
// State table:  SIDLE | wait for AW    SDATA | burst in flight    SRESP | B pending    SDEFO | illegal-state trap
module wreq_sched_subo #(
    parameter int QDEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         awvalid,
    output logic         awready,
    input  logic [31:0]  awaddr,
    input  logic [7:0]   awlen,
    output logic         next_srq,
    input  logic         finish_swd,
    input  logic [127:0] wdat_s_data,
    output logic         sqfull_1,
    output logic         bvalid,
    input  logic         bready,
    output logic [1:0]   bresp,
    output logic         wq_valid,
    output logic [31:0]  wq_addr,
    output logic [127:0] wq_data,
    input  logic         wq_pop
);

    localparam int PW = $clog2(QDEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] CNT_FULL  = CW'(QDEPTH);
    localparam logic [CW-1:0] CNT_NEAR  = CW'(QDEPTH - 1);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);
    localparam logic [PW-1:0] PTR_ONE   = PW'(1);

    typedef enum logic [1:0] {
        SIDLE = 2'b00,
        SDATA = 2'b01,
        SRESP = 2'b10,
        SDEFO = 2'b11
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [CW-1:0]   r_count;
    logic [CW-1:0]   w_count_nxt;
    logic [PW-1:0]   r_wptr;
    logic [PW-1:0]   r_rptr;
    logic            r_next_srq;
    logic            r_sqfull;
    logic [1:0]      r_bresp;
    logic [31:0]     r_addr;
    logic [31:0]     r_mem_addr [QDEPTH];
    logic [127:0]    r_mem_data [QDEPTH];

    logic            w_aw_space;
    logic            w_aw_fire;
    logic            w_push;
    logic            w_pop;
    logic            w_resp_ld;
    logic            w_len_err;
    logic [1:0]      w_bresp_nxt;
    logic            w_unused;

`ifdef WREQ_LENCHK_EN
    logic [7:0]      r_len;

    always_ff @(posedge clk) begin
        if (w_aw_fire) r_len <= awlen;
    end

    assign w_len_err = (r_len > 8'd3);
    assign w_unused  = 1'b0;
`else
    // Without the check the length has no effect; only the legal bits are kept.
    logic [1:0]      r_len;

    always_ff @(posedge clk) begin
        if (w_aw_fire) r_len <= awlen[1:0];
    end

    assign w_len_err = 1'b0;
    assign w_unused  = ^{awlen[7:2], r_len};
`endif

    assign w_aw_space  = (r_count < CNT_FULL);
    assign w_bresp_nxt = w_len_err ? 2'b10 : 2'b00;
    assign w_pop       = wq_pop && (r_count != '0);

    always_comb begin
        w_state_nxt = r_state;
        w_aw_fire   = 1'b0;
        w_push      = 1'b0;
        w_resp_ld   = 1'b0;
        awready     = 1'b0;
        case (r_state)
            SIDLE: begin
                awready = w_aw_space;
                if (awvalid && w_aw_space) begin
                    w_aw_fire   = 1'b1;
                    w_state_nxt = SDATA;
                end
            end
            SDATA: begin
                if (finish_swd) begin
                    w_resp_ld   = 1'b1;
                    w_push      = !w_len_err;
                    w_state_nxt = SRESP;
                end
            end
            SRESP: begin
                if (bready) w_state_nxt = SIDLE;
            end
            default: w_state_nxt = SDEFO;
        endcase
    end

    always_comb begin
        w_count_nxt = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_nxt = r_count + CNT_ONE;
            2'b01:   w_count_nxt = r_count - CNT_ONE;
            default: w_count_nxt = r_count;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= SIDLE;
            r_count    <= '0;
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_next_srq <= 1'b0;
            r_sqfull   <= 1'b0;
            r_bresp    <= 2'b00;
        end else begin
            r_state    <= w_state_nxt;
            r_count    <= w_count_nxt;
            r_next_srq <= w_aw_fire;
            r_sqfull   <= (w_count_nxt >= CNT_NEAR);
            if (w_resp_ld) r_bresp <= w_bresp_nxt;
            if (w_push)    r_wptr  <= r_wptr + PTR_ONE;
            if (w_pop)     r_rptr  <= r_rptr + PTR_ONE;
        end
    end

    // Storage and the address latch carry no reset; count gates their visibility.
    always_ff @(posedge clk) begin
        if (w_aw_fire) r_addr <= awaddr;
        if (w_push) begin
            r_mem_addr[r_wptr] <= r_addr;
            r_mem_data[r_wptr] <= wdat_s_data;
        end
    end

    assign next_srq = r_next_srq;
    assign sqfull_1 = r_sqfull;
    assign bvalid   = (r_state == SRESP);
    assign bresp    = r_bresp;
    assign wq_valid = (r_count != '0);
    assign wq_addr  = r_mem_addr[r_rptr];
    assign wq_data  = r_mem_data[r_rptr];

endmodule

// File: tb/tb_wreq_sched_subo.sv
// Directed bench for wreq_sched_subo (QDEPTH=4), honours WREQ_LENCHK_EN when defined.
module tb_wreq_sched_subo;

    logic         clk;
    logic         rst;
    logic         awvalid;
    logic         awready;
    logic [31:0]  awaddr;
    logic [7:0]   awlen;
    logic         next_srq;
    logic         finish_swd;
    logic [127:0] wdat_s_data;
    logic         sqfull_1;
    logic         bvalid;
    logic         bready;
    logic [1:0]   bresp;
    logic         wq_valid;
    logic [31:0]  wq_addr;
    logic [127:0] wq_data;
    logic         wq_pop;

    int n_chk = 0;
    int n_err = 0;

    logic [31:0]  m_addr [$];
    logic [127:0] m_data [$];

`ifdef WREQ_LENCHK_EN
    localparam logic [1:0] LEN_RESP = 2'b10;
    localparam bit         LEN_PUSH = 1'b0;
`else
    localparam logic [1:0] LEN_RESP = 2'b00;
    localparam bit         LEN_PUSH = 1'b1;
`endif

    wreq_sched_subo #(.QDEPTH(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .awvalid     (awvalid),
        .awready     (awready),
        .awaddr      (awaddr),
        .awlen       (awlen),
        .next_srq    (next_srq),
        .finish_swd  (finish_swd),
        .wdat_s_data (wdat_s_data),
        .sqfull_1    (sqfull_1),
        .bvalid      (bvalid),
        .bready      (bready),
        .bresp       (bresp),
        .wq_valid    (wq_valid),
        .wq_addr     (wq_addr),
        .wq_data     (wq_data),
        .wq_pop      (wq_pop)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(negedge clk);
    endtask

    function automatic logic [127:0] mkdat(input logic [31:0] a);
        return {a + 32'd3, a + 32'd2, a + 32'd1, a};
    endfunction

    task automatic model_check;
        chk("wq_valid", wq_valid, m_addr.size() != 0);
        if (m_addr.size() != 0) begin
            chk("wq_addr", wq_addr, m_addr[0]);
            chk("wq_data", wq_data, m_data[0]);
        end
        chk("sqfull", sqfull_1, m_addr.size() >= 3);
    endtask

    // Completes a burst already in SDATA: finish pulse, optional B hold, then bready.
    task automatic finish_part(input logic [127:0] d, input int hold, input bit pop_too,
                               input logic [1:0] exp_resp, input bit exp_push);
        chk("srq_low", next_srq, 1'b0);
        chk("bvalid_data", bvalid, 1'b0);
        finish_swd = 1'b1; wdat_s_data = d; wq_pop = pop_too;
        tick;
        finish_swd = 1'b0; wq_pop = 1'b0;
        if (pop_too && m_addr.size() != 0) begin
            void'(m_addr.pop_front());
            void'(m_data.pop_front());
        end
        if (exp_push) begin
            m_addr.push_back(awaddr);
            m_data.push_back(d);
        end
        chk("bvalid_set", bvalid, 1'b1);
        chk("bresp", bresp, exp_resp);
        model_check;
        for (int i = 0; i < hold; i++) begin
            tick;
            chk("bvalid_hold", bvalid, 1'b1);
            chk("bresp_hold", bresp, exp_resp);
            chk("awready_hold", awready, 1'b0);
        end
        bready = 1'b1;
        tick;
        bready = 1'b0;
        chk("bvalid_clr", bvalid, 1'b0);
        chk("awready_after_b", awready, m_addr.size() < 4);
    endtask

    task automatic burst(input logic [31:0] a, input logic [7:0] len, input logic [127:0] d,
                         input int hold, input bit pop_too,
                         input logic [1:0] exp_resp, input bit exp_push);
        chk("awready_idle", awready, 1'b1);
        awvalid = 1'b1; awaddr = a; awlen = len;
        tick;
        awvalid = 1'b0;
        chk("srq_pulse", next_srq, 1'b1);
        chk("awready_busy", awready, 1'b0);
        tick;
        finish_part(d, hold, pop_too, exp_resp, exp_push);
    endtask

    task automatic do_pop;
        wq_pop = 1'b1;
        tick;
        wq_pop = 1'b0;
        if (m_addr.size() != 0) begin
            void'(m_addr.pop_front());
            void'(m_data.pop_front());
        end
        model_check;
    endtask

    initial begin
        rst = 1'b1; awvalid = 1'b0; awaddr = '0; awlen = '0;
        finish_swd = 1'b0; wdat_s_data = '0; bready = 1'b0; wq_pop = 1'b0;
        repeat (3) tick;
        rst = 1'b0;
        chk("rst_awready", awready, 1'b1);
        chk("rst_srq", next_srq, 1'b0);
        chk("rst_bvalid", bvalid, 1'b0);
        chk("rst_bresp", bresp, 2'b00);
        chk("rst_sqfull", sqfull_1, 1'b0);
        chk("rst_wq_valid", wq_valid, 1'b0);

        // single burst with the reference data pattern
        burst(32'h100, 8'd3, 128'h44444444_33333333_22222222_11111111, 0, 1'b0, 2'b00, 1'b1);

        // stray finish/bready in SIDLE must do nothing
        finish_swd = 1'b1; bready = 1'b1; wdat_s_data = '1;
        tick;
        finish_swd = 1'b0; bready = 1'b0;
        chk("stray_bvalid", bvalid, 1'b0);
        chk("stray_awready", awready, 1'b1);
        model_check;

        // fill to QDEPTH
        burst(32'h200, 8'd1, mkdat(32'h200), 0, 1'b0, 2'b00, 1'b1);
        burst(32'h300, 8'd2, mkdat(32'h300), 0, 1'b0, 2'b00, 1'b1);
        chk("sqfull_at3", sqfull_1, 1'b1);
        burst(32'h400, 8'd0, mkdat(32'h400), 0, 1'b0, 2'b00, 1'b1);
        chk("awready_full", awready, 1'b0);

        // 5th AW stalls until a pop
        awvalid = 1'b1; awaddr = 32'h500; awlen = 8'd3;
        for (int i = 0; i < 3; i++) begin
            tick;
            chk("stall_awready", awready, 1'b0);
            chk("stall_srq", next_srq, 1'b0);
        end
        do_pop;
        chk("unstall_awready", awready, 1'b1);
        chk("unstall_srq", next_srq, 1'b0);
        tick;
        awvalid = 1'b0;
        chk("stall_srq_pulse", next_srq, 1'b1);
        chk("stall_awready_busy", awready, 1'b0);
        tick;
        finish_part(mkdat(32'h500), 0, 1'b0, 2'b00, 1'b1);

        // down to two, then push+pop together across pointer wrap
        do_pop;
        do_pop;
        for (int k = 0; k < 6; k++) begin
            burst(32'h1000 + 32'(k) * 32'h40, 8'd3, mkdat(32'hA000 + 32'(k)), 0, 1'b1, 2'b00, 1'b1);
            chk("pp_count2", m_addr.size() == 2 && wq_valid && !sqfull_1, 1'b1);
        end

        // long B backpressure
        burst(32'h2000, 8'd2, mkdat(32'h2000), 5, 1'b0, 2'b00, 1'b1);
        do_pop;

        // oversize burst length
        burst(32'h3000, 8'd5, mkdat(32'h3000), 0, 1'b0, LEN_RESP, LEN_PUSH);
        while (m_addr.size() > 2) do_pop;

        // reset while in SDATA with two queued entries
        chk("pre_rst_wq_valid", wq_valid, 1'b1);
        awvalid = 1'b1; awaddr = 32'h4000; awlen = 8'd1;
        tick;
        awvalid = 1'b0;
        chk("pre_rst_srq", next_srq, 1'b1);
        rst = 1'b1;
        tick;
        rst = 1'b0;
        m_addr.delete();
        m_data.delete();
        chk("mid_rst_srq", next_srq, 1'b0);
        chk("mid_rst_bvalid", bvalid, 1'b0);
        chk("mid_rst_awready", awready, 1'b1);
        model_check;

        // a late finish from the discarded burst is ignored
        finish_swd = 1'b1;
        tick;
        finish_swd = 1'b0;
        chk("post_rst_bvalid", bvalid, 1'b0);
        model_check;

        burst(32'h5000, 8'd3, mkdat(32'h5000), 0, 1'b0, 2'b00, 1'b1);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
